// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped BTB with 2-bit saturating counters,
// E-stage mispredict detection and saturating branch/mispredict statistics.
module branch_target_predictor #(
   parameter int         XLEN     = 32,
   parameter int         ENTRIES  = 16,
   parameter int         CNT_W    = 16,
   parameter logic [1:0] INIT_CTR = 2'b01
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [XLEN-1:0]  PCF,
   output logic             PredTakenF,
   output logic [XLEN-1:0]  NextPCF,
   input  logic             UpdateE,
   input  logic [XLEN-1:0]  PCE,
   input  logic             TakenE,
   input  logic [XLEN-1:0]  TargetE,
   input  logic             IsJumpE,
   input  logic             PredTakenE,
   input  logic [XLEN-1:0]  PredTargetE,
   output logic             MispredictE,
   output logic [XLEN-1:0]  RecoverPCE,
   input  logic             ClearStats,
   output logic [CNT_W-1:0] BranchCount,
   output logic [CNT_W-1:0] MispredCount
);
   localparam int IDX   = $clog2(ENTRIES);
   localparam int TAG_W = XLEN - IDX - 2;

   logic [ENTRIES-1:0] valid_q;
   logic [ENTRIES-1:0] jmp_q;
   logic [TAG_W-1:0]   tag_q [ENTRIES];
   logic [XLEN-1:0]    tgt_q [ENTRIES];
   logic [1:0]         ctr_q [ENTRIES];
   logic [CNT_W-1:0]   bcnt_q, bcnt_d, mcnt_q, mcnt_d;

   logic [IDX-1:0]   fidx, eidx;
   logic [TAG_W-1:0] ftag, etag;
   logic             fhit, ehit, we;
   logic [1:0]       ectr, ctr_d;
   logic [XLEN-1:0]  tgt_d;

   assign fidx = PCF[IDX+1:2];
   assign ftag = PCF[XLEN-1:IDX+2];
   assign eidx = PCE[IDX+1:2];
   assign etag = PCE[XLEN-1:IDX+2];

   assign fhit       = valid_q[fidx] && (tag_q[fidx] == ftag);
   assign PredTakenF = fhit && (ctr_q[fidx][1] || jmp_q[fidx]);
   assign NextPCF    = PredTakenF ? tgt_q[fidx] : PCF + XLEN'(4);

   assign MispredictE = UpdateE && ((PredTakenE != TakenE) ||
                                    (TakenE && PredTakenE && (PredTargetE != TargetE)));
   assign RecoverPCE  = TakenE ? TargetE : PCE + XLEN'(4);

   // a miss that was not taken leaves the table alone
   assign ehit  = valid_q[eidx] && (tag_q[eidx] == etag);
   assign we    = UpdateE && (ehit || TakenE);
   assign ectr  = ctr_q[eidx];

   always_comb begin
      ctr_d = ehit ? (TakenE ? ((ectr == 2'b11) ? ectr : ectr + 2'd1)
                             : ((ectr == 2'b00) ? ectr : ectr - 2'd1))
                   : (IsJumpE ? 2'b11 : 2'b10);
      tgt_d = TakenE ? TargetE : tgt_q[eidx];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         jmp_q   <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i] <= '0;
            tgt_q[i] <= '0;
            ctr_q[i] <= INIT_CTR;
         end
      end else if (we) begin
         valid_q[eidx] <= 1'b1;
         jmp_q[eidx]   <= IsJumpE;
         tag_q[eidx]   <= etag;
         tgt_q[eidx]   <= tgt_d;
         ctr_q[eidx]   <= ctr_d;
      end
   end

   always_comb begin
      bcnt_d = ClearStats ? '0 : (UpdateE && !(&bcnt_q)) ? bcnt_q + CNT_W'(1) : bcnt_q;
      mcnt_d = ClearStats ? '0 : (MispredictE && !(&mcnt_q)) ? mcnt_q + CNT_W'(1) : mcnt_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bcnt_q <= '0;
         mcnt_q <= '0;
      end else begin
         bcnt_q <= bcnt_d;
         mcnt_q <= mcnt_d;
      end
   end

   assign BranchCount  = bcnt_q;
   assign MispredCount = mcnt_q;
endmodule
